// File: rtl/booth_pp_sum_18x18_pkg.sv
//============================================================================
// Module   : mult_pkg
// Brief    : Shared widths, product type and partial-product alignment
//            helper for the 18x18 Booth multiplier datapath.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package mult_pkg;

    localparam int PP_N   = 10;
    localparam int PP_W   = 20;
    localparam int PROD_W = 36;

    typedef logic [PROD_W-1:0] prod_t;

    // Sign-extend a partial product to product width and place it at
    // weight 4^idx; bits pushed past the top are dropped by the shift.
    function automatic prod_t pp_align(input logic [PP_W-1:0] pp, input int idx);
        prod_t ext;
        ext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
        return ext << (2 * idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_sum_18x18_if.sv
//============================================================================
// Module   : booth_pp_sum_18x18_if
// Brief    : Valid/ready partial-product input bus and product output bus
//            of the Booth partial-product summation stage.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface booth_pp_sum_18x18_if;
    import mult_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic [PP_W-1:0] i_pp1;
    logic [PP_W-1:0] i_pp2;
    logic [PP_W-1:0] i_pp3;
    logic [PP_W-1:0] i_pp4;
    logic [PP_W-1:0] i_pp5;
    logic [PP_W-1:0] i_pp6;
    logic [PP_W-1:0] i_pp7;
    logic [PP_W-1:0] i_pp8;
    logic [PP_W-1:0] i_pp9;
    logic [PP_W-1:0] i_pp10;
    logic            o_valid;
    logic            i_ready;
    prod_t           o_prod;

    // Summation block side
    modport slave (
        input  i_valid, i_pp1, i_pp2, i_pp3, i_pp4, i_pp5,
               i_pp6, i_pp7, i_pp8, i_pp9, i_pp10, i_ready,
        output o_ready, o_valid, o_prod
    );

    // Partial-product source / product sink side
    modport master (
        output i_valid, i_pp1, i_pp2, i_pp3, i_pp4, i_pp5,
               i_pp6, i_pp7, i_pp8, i_pp9, i_pp10, i_ready,
        input  o_ready, o_valid, o_prod
    );

endinterface

`default_nettype wire

// File: rtl/booth_pp_sum_18x18_csa.sv
//============================================================================
// Module   : csa_3to2
// Brief    : W-bit 3:2 carry-save adder row. Carry is returned already
//            shifted to its weight and truncated to W bits.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module csa_3to2 #(
    parameter int W = 36
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    // Majority of the top bit would land above bit W-1, so it is never formed.
    assign o_carry = {(i_a[W-2:0] & i_b[W-2:0]) |
                      (i_a[W-2:0] & i_c[W-2:0]) |
                      (i_b[W-2:0] & i_c[W-2:0]), 1'b0};

endmodule

`default_nettype wire

// File: rtl/booth_pp_sum_18x18.sv
//============================================================================
// Module   : booth_pp_sum_18x18
// Brief    : Three-stage pipelined reduction of ten radix-4 Booth partial
//            products into a 36-bit product (CSA 10->4, CSA 4->2, CPA),
//            with valid/ready back-pressure through every stage.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module booth_pp_sum_18x18
    import mult_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    booth_pp_sum_18x18_if.slave  bus
);

    logic [PP_W-1:0] w_pp [PP_N];
    prod_t           w_t  [PP_N];

    assign w_pp[0] = bus.i_pp1;
    assign w_pp[1] = bus.i_pp2;
    assign w_pp[2] = bus.i_pp3;
    assign w_pp[3] = bus.i_pp4;
    assign w_pp[4] = bus.i_pp5;
    assign w_pp[5] = bus.i_pp6;
    assign w_pp[6] = bus.i_pp7;
    assign w_pp[7] = bus.i_pp8;
    assign w_pp[8] = bus.i_pp9;
    assign w_pp[9] = bus.i_pp10;

    for (genvar gi = 0; gi < PP_N; gi++) begin : g_align
        assign w_t[gi] = pp_align(w_pp[gi], gi);
    end

    // ---------------- Stage 1: 10 -> 7 -> 5 -> 4 ----------------
    prod_t w_l1_s [3];
    prod_t w_l1_c [3];
    prod_t w_l2a_s, w_l2a_c, w_l2b_s, w_l2b_c;
    prod_t w_l3_s, w_l3_c;

    for (genvar gj = 0; gj < 3; gj++) begin : g_l1
        csa_3to2 #(.W(PROD_W)) u_csa (
            .i_a(w_t[3*gj]), .i_b(w_t[3*gj+1]), .i_c(w_t[3*gj+2]),
            .o_sum(w_l1_s[gj]), .o_carry(w_l1_c[gj])
        );
    end

    csa_3to2 #(.W(PROD_W)) u_csa_l2a (
        .i_a(w_l1_s[0]), .i_b(w_l1_c[0]), .i_c(w_l1_s[1]),
        .o_sum(w_l2a_s), .o_carry(w_l2a_c)
    );

    csa_3to2 #(.W(PROD_W)) u_csa_l2b (
        .i_a(w_l1_c[1]), .i_b(w_l1_s[2]), .i_c(w_l1_c[2]),
        .o_sum(w_l2b_s), .o_carry(w_l2b_c)
    );

    csa_3to2 #(.W(PROD_W)) u_csa_l3 (
        .i_a(w_l2a_s), .i_b(w_l2a_c), .i_c(w_l2b_s),
        .o_sum(w_l3_s), .o_carry(w_l3_c)
    );

    // ---------------- Handshake: each stage advances if empty or drained ----------------
    logic r_s1_valid, r_s2_valid, r_o_valid;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3 = !r_o_valid  || bus.i_ready;
    assign w_adv2 = !r_s2_valid || w_adv3;
    assign w_adv1 = !r_s1_valid || w_adv2;

    assign bus.o_ready = w_adv1;

    prod_t r_s1_op [4];

    // Stage 1 register: capture the four remaining operands with their valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_s1_op[i] <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.i_valid;
            r_s1_op[0] <= w_l3_s;
            r_s1_op[1] <= w_l3_c;
            r_s1_op[2] <= w_l2b_c;
            r_s1_op[3] <= w_t[9];
        end
    end

    // ---------------- Stage 2: 4 -> 3 -> 2 ----------------
    prod_t w_s2a_s, w_s2a_c, w_s2b_s, w_s2b_c;
    prod_t r_s2_sum, r_s2_carry;

    csa_3to2 #(.W(PROD_W)) u_csa_s2a (
        .i_a(r_s1_op[0]), .i_b(r_s1_op[1]), .i_c(r_s1_op[2]),
        .o_sum(w_s2a_s), .o_carry(w_s2a_c)
    );

    csa_3to2 #(.W(PROD_W)) u_csa_s2b (
        .i_a(w_s2a_s), .i_b(w_s2a_c), .i_c(r_s1_op[3]),
        .o_sum(w_s2b_s), .o_carry(w_s2b_c)
    );

    // Stage 2 register: redundant sum/carry pair
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_carry <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sum   <= w_s2b_s;
            r_s2_carry <= w_s2b_c;
        end
    end

    // ---------------- Stage 3: carry-propagate add ----------------
    prod_t r_o_prod;

    // Output register: final product, carry out of bit 35 discarded
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_o_prod  <= '0;
        end else if (w_adv3) begin
            r_o_valid <= r_s2_valid;
            r_o_prod  <= r_s2_sum + r_s2_carry;
        end
    end

    assign bus.o_valid = r_o_valid;
    assign bus.o_prod  = r_o_prod;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_sum_18x18.sv
//============================================================================
// Module   : tb_booth_pp_sum_18x18
// Brief    : Self-checking bench: operands are Booth-recoded into partial
//            products and results are compared with a plain a*b model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_booth_pp_sum_18x18;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    booth_pp_sum_18x18_if bus ();

    booth_pp_sum_18x18 dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cnt = 0;
    int          n_in = 0;
    int          n_out = 0;
    int          stall_cnt = 0;
    int          ready_mode = 0;
    int          w0 = 0;
    int          w1 = 0;
    bit          lat_mode = 1'b0;
    longint      cur_a = 0;
    longint      cur_b = 0;
    logic [35:0] last_prod = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Operand value as the multiplier sees it (signed or unsigned 18-bit)
    function automatic longint opval(input logic [17:0] raw, input bit s);
        if (s && raw[17]) return longint'(raw) - 64'sd262144;
        return longint'(raw);
    endfunction

    function automatic logic [35:0] model(input longint a, input longint b);
        longint p;
        p = a * b;
        return p[35:0];
    endfunction

    // Radix-4 Booth partial product k of a*b (b taken as a 20-bit signed value)
    function automatic logic [19:0] booth_pp(input longint a, input longint b, input int k);
        logic [20:0] bx;
        logic [2:0]  g;
        longint      d;
        longint      p;
        bx = {b[19:0], 1'b0};
        g  = bx[2*k+2 -: 3];
        d  = -2 * longint'(g[2]) + longint'(g[1]) + longint'(g[0]);
        p  = a * d;
        return p[19:0];
    endfunction

    task automatic put(input logic [17:0] ra, input bit sa, input logic [17:0] rb, input bit sb_);
        cur_a       = opval(ra, sa);
        cur_b       = opval(rb, sb_);
        bus.i_pp1   = booth_pp(cur_a, cur_b, 0);
        bus.i_pp2   = booth_pp(cur_a, cur_b, 1);
        bus.i_pp3   = booth_pp(cur_a, cur_b, 2);
        bus.i_pp4   = booth_pp(cur_a, cur_b, 3);
        bus.i_pp5   = booth_pp(cur_a, cur_b, 4);
        bus.i_pp6   = booth_pp(cur_a, cur_b, 5);
        bus.i_pp7   = booth_pp(cur_a, cur_b, 6);
        bus.i_pp8   = booth_pp(cur_a, cur_b, 7);
        bus.i_pp9   = booth_pp(cur_a, cur_b, 8);
        bus.i_pp10  = booth_pp(cur_a, cur_b, 9);
        bus.i_valid = 1'b1;
    endtask

    task automatic wait_acc();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] ra, input bit sa, input logic [17:0] rb, input bit sb_);
        put(ra, sa, rb, sb_);
        wait_acc();
    endtask

    task automatic send_rand();
        send(18'($urandom_range(0, 262143)), 1'($urandom % 2),
             18'($urandom_range(0, 262143)), 1'($urandom % 2));
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cnt == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Edge counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready pattern, applied after the driver's own updates
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = ($urandom_range(0, 3) != 0);
            2:       bus.i_ready = 1'b0;
            default: bus.i_ready = !(cyc >= w0 && cyc < w1);
        endcase
    end

    // Scoreboard: transfers seen here happen at the next rising edge
    initial forever begin
        bit   acc;
        bit   emt;
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            acc = bus.i_valid && bus.o_ready;
            emt = bus.o_valid && bus.i_ready;
            chk("o_ready", 64'(bus.o_ready), 64'((cnt < 3) || bus.i_ready));
            if (!bus.o_ready) stall_cnt++;
            if (emt) begin
                if (sb.size() == 0) begin
                    chk("stray_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("prod", 64'(bus.o_prod), 64'(e.prod));
                    if (lat_mode) chk("latency", 64'(cyc - e.cyc), 3);
                    last_prod = bus.o_prod;
                    n_out++;
                end
            end
            if (acc) begin
                sb.push_back('{prod: model(cur_a, cur_b), cyc: cyc});
                n_in++;
            end
            cnt = cnt + int'(acc) - int'(emt);
        end
    end

    initial begin
        int n0;
        int m0;
        bus.i_ready = 1'b1;
        put(18'd0, 1'b0, 18'd0, 1'b0);
        bus.i_valid = 1'b0;
        lat_mode    = 1'b1;
        #1;
        rst = 1'b1;

        // Reset with a valid set presented: nothing moves
        put(18'd5, 1'b0, 18'd7, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_o_valid", 64'(bus.o_valid), 0);
            chk("rst_o_prod",  64'(bus.o_prod), 0);
            chk("rst_o_ready", 64'(bus.o_ready), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_acc();
        idle();
        drain();
        chk("first_prod", 64'(last_prod), 64'd35);

        // Directed corner operands
        send(18'h3FFFF, 1'b0, 18'h3FFFF, 1'b0);
        idle();
        drain();
        chk("umax_x_umax", 64'(last_prod), 64'h0_FFFF_80001);

        send(18'h20000, 1'b1, 18'h20000, 1'b1);
        idle();
        drain();
        chk("smin_x_smin", 64'(last_prod), 64'h4_0000_0000);

        send(18'h3FFFF, 1'b1, 18'd3, 1'b0);
        idle();
        drain();
        chk("neg1_x_3", 64'(last_prod), 64'hF_FFFF_FFFD);

        // Back-pressure window on cycles 2..7 of an 8-set stream
        lat_mode   = 1'b0;
        n0         = n_in;
        m0         = n_out;
        stall_cnt  = 0;
        w0         = cyc + 2;
        w1         = cyc + 8;
        ready_mode = 3;
        repeat (8) send_rand();
        idle();
        while (cyc < w1) @(posedge clk);
        #1;
        ready_mode = 0;
        drain();
        chk("bp_stall_seen", 64'(stall_cnt > 0), 1);
        chk("bp_in_count",   64'(n_in - n0), 8);
        chk("bp_out_count",  64'(n_out - m0), 8);

        // Long random stream with random downstream ready
        ready_mode = 1;
        repeat (1000) send_rand();
        idle();
        ready_mode = 0;
        drain();
        chk("io_count", 64'(n_out), 64'(n_in));
        chk("sb_empty", 64'(sb.size()), 0);

        // Asynchronous reset with the pipeline full
        ready_mode = 2;
        repeat (3) send_rand();
        idle();
        @(negedge clk);
        chk("full_o_valid", 64'(bus.o_valid), 1);
        chk("full_o_ready", 64'(bus.o_ready), 0);
        #2;
        rst = 1'b1;
        sb.delete();
        cnt = 0;
        #1;
        chk("arst_o_valid", 64'(bus.o_valid), 0);
        chk("arst_o_prod",  64'(bus.o_prod), 0);
        chk("arst_o_ready", 64'(bus.o_ready), 1);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_o_valid", 64'(bus.o_valid), 0);
        end
        @(posedge clk);
        #1;

        // Pipeline still works after reset
        lat_mode = 1'b1;
        send(18'h1FFFF, 1'b1, 18'h3FFFE, 1'b1);
        idle();
        drain();
        chk("after_rst_prod", 64'(last_prod), 64'h0_FFFF_C0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
